timer_arbiter: RTL and testbench
================================

# timer_arbiter

Shared timed-interval scheduler for the rover controller. One prescaler turns the system clock into a slow tick (DIV clock cycles per tick, 1 s at 50 MHz by default). A round-robin arbiter lends that single timer to up to NUM_REQ requesters (drive, steering, sensor-sweep sequencers). Each requester asks for a duration in ticks and receives a one-cycle completion pulse when it expires.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- DIV, 50000000: clk cycles per tick, ≥ 2, < 2^32.
- CNT_W, 16: duration width in ticks.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- req  in  NUM_REQ  per-requester request level.
- dur  in  NUM_REQ*CNT_W  packed durations; requester i at bits [i*CNT_W +: CNT_W].
- grant  out  NUM_REQ  one-hot; high while requester owns the running timer.
- done  out  NUM_REQ  one-cycle completion pulse, one-hot.
- busy  out  1  high whenever state ≠ IDLE.
- tick  out  1  one-cycle pulse at each prescaler expiry while in RUN.

## Operation
- States: IDLE, RUN, DONE. Internal registers: 32-bit prescaler `pcnt`, CNT_W-bit `remain`, owner index `own`, last-served pointer `last`.
- IDLE:
  - If req ≠ 0, pick the winner round-robin. Search order is last+1, last+2, … modulo NUM_REQ.
  - On that edge: own ← winner, remain ← dur[winner], pcnt ← 0.
  - If dur[winner] ≠ 0, grant[winner] ← 1 and go to RUN.
  - If dur[winner] = 0, go directly to DONE with no grant and no ticks.
- RUN:
  - pcnt counts 0..DIV-1 and wraps.
  - tick is high in the cycle pcnt = DIV-1; remain decrements on that edge.
  - If remain = 1 on a tick, go to DONE.
- DONE:
  - done[own] = 1 for this single cycle; grant is 0.
  - last ← own; return to IDLE.
- Fairness: the just-served requester has lowest priority in the next arbitration. A requester that keeps req high re-arbitrates the cycle after DONE.
- Requester contract: hold req high and dur stable from assertion until its done pulse. Drop req in the cycle after done, unless it wants another interval.
- dur is sampled only on the IDLE→RUN/DONE edge. Changes to dur during RUN are ignored.
- Requests from non-owners during RUN/DONE are held off; no loss, since req is a level.
- Reset: state ← IDLE, last ← NUM_REQ-1 (requester 0 first), pcnt ← 0, remain ← 0. Outputs after reset: grant = 0, done = 0, busy = 0, tick = 0. Reset asserted mid-RUN discards the interval with no done pulse.

## Timing
- req seen in IDLE at cycle C: grant high from C+1.
- For dur = N ≥ 1: ticks occur at C+k·DIV for k = 1..N. done is high at C+N·DIV+1, and grant falls in the same cycle.
- Total occupancy is N·DIV+1 cycles. IDLE is then re-entered at C+N·DIV+2, so there is one idle arbitration cycle between back-to-back intervals.
- dur = 0: done at C+1, busy high for that one cycle.
- pcnt arithmetic is unsigned 32-bit. The compare is against DIV-1 and pcnt never exceeds it.

## Configuration
- Macro TIMER_ARBITER_ABORT_EN.
- Defined: if req[own] falls while in RUN, the interval aborts on that edge. grant drops the next cycle, there is no done pulse and no further tick, last ← own, and the state returns to IDLE.
- Not defined: req[own] is ignored after grant. The interval always runs to completion and emits done.

## Test plan
All scenarios use DIV=4, NUM_REQ=4, CNT_W=8.
- Reset: hold rst 3 cycles with req=4'b1111 → grant=0, done=0, busy=0, tick=0. After release, requester 0 is granted first.
- Single request: req[2]=1, dur=3 seen at cycle C → grant=4'b0100 from C+1; ticks at C+4, C+8, C+12; done=4'b0100 at C+13 only.
- Round-robin: req=4'b1011 held, all dur=1 → grant order 0, 1, 3, 0, 1, 3; exactly one done per interval; no grant while another is active.
- Zero duration: req[1]=1, dur=0 → done[1] one cycle after request seen; grant never asserted; no tick.
- Abort, macro defined: req[0] dur=5 dropped 6 cycles into RUN → grant falls next cycle, no done, busy=0 afterwards. Same stimulus without the macro → done[0] at C+21.
- Reset mid-run: assert rst during RUN → all outputs 0 next cycle; no done pulse; with req still high, arbitration restarts at requester 0.

Source files
------------

// File: rtl/timer_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : timer_arbiter
//  Description : One shared prescaled interval timer lent round-robin to
//                NUM_REQ requesters; each gets a one-cycle done pulse when its
//                requested number of ticks has elapsed.
//                Optional macro TIMER_ARBITER_ABORT_EN: the owner dropping its
//                request while running aborts the interval without done.
//  Revision    : 1.0 - initial release
// ============================================================================
module timer_arbiter #(
  parameter int          NUM_REQ = 4,
  parameter int unsigned DIV     = 50000000,
  parameter int          CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*CNT_W-1:0] dur,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy,
  output logic                     tick
);

  localparam int          IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [31:0] DIV_M1 = 32'(DIV - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [31:0]        pcnt_q, pcnt_d;
  logic [CNT_W-1:0]   remain_q, remain_d;
  logic [IDX_W-1:0]   own_q, own_d;
  logic [IDX_W-1:0]   last_q, last_d;

  logic [IDX_W-1:0]   w_win;
  logic [CNT_W-1:0]   w_win_dur;
  logic               w_abort;
  logic               w_expire;
  logic [NUM_REQ-1:0] w_own_oh;

  // Round-robin search starting just after the last served requester; the
  // loop runs from farthest to nearest so the nearest requester wins.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [IDX_W-1:0]   last);
    logic [IDX_W-1:0] pick;
    int               idx;
    pick = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(last) + k) % NUM_REQ;
      if (r[idx]) pick = IDX_W'(idx);
    end
    return pick;
  endfunction

  assign w_win     = rr_pick(req, last_q);
  assign w_win_dur = dur[int'(w_win)*CNT_W +: CNT_W];
  assign w_own_oh  = {{(NUM_REQ-1){1'b0}}, 1'b1} << own_q;

`ifdef TIMER_ARBITER_ABORT_EN
  assign w_abort = (state_q == S_RUN) && !req[own_q];
`else
  assign w_abort = 1'b0;
`endif

  // Prescaler expiry inside a running, non-aborting interval.
  assign w_expire = (state_q == S_RUN) && (pcnt_q == DIV_M1) && !w_abort;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (|req) state_d = (w_win_dur != '0) ? S_RUN : S_DONE;
      end
      S_RUN: begin
        if (w_abort)                                   state_d = S_IDLE;
        else if (w_expire && (remain_q == CNT_W'(1)))  state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath registers: prescaler, remaining ticks, owner and last served.
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt_q   <= '0;
      remain_q <= '0;
      own_q    <= '0;
      last_q   <= IDX_W'(NUM_REQ - 1);
    end else begin
      pcnt_q   <= pcnt_d;
      remain_q <= remain_d;
      own_q    <= own_d;
      last_q   <= last_d;
    end
  end

  // Datapath next values: capture on grant, count while running, record
  // the owner as last served when its interval ends or aborts.
  always_comb begin
    pcnt_d   = pcnt_q;
    remain_d = remain_q;
    own_d    = own_q;
    last_d   = last_q;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          own_d    = w_win;
          remain_d = w_win_dur;
          pcnt_d   = '0;
        end
      end
      S_RUN: begin
        if (w_abort) begin
          last_d = own_q;
        end else if (pcnt_q == DIV_M1) begin
          pcnt_d   = '0;
          remain_d = remain_q - CNT_W'(1);
        end else begin
          pcnt_d = pcnt_q + 32'd1;
        end
      end
      S_DONE:  last_d = own_q;
      default: ;
    endcase
  end

  // Outputs decoded from the registered state.
  always_comb begin
    grant = '0;
    done  = '0;
    busy  = (state_q != S_IDLE);
    tick  = w_expire;
    if (state_q == S_RUN)  grant = w_own_oh;
    if (state_q == S_DONE) done  = w_own_oh;
  end

endmodule
`default_nettype wire

// File: tb/tb_timer_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_timer_arbiter
//  Description : Directed self-checking bench for timer_arbiter with DIV=4,
//                NUM_REQ=4, CNT_W=8. Abort expectations follow
//                TIMER_ARBITER_ABORT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_timer_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DIV     = 4;
  localparam int CNT_W   = 8;

  logic                     clk;
  logic                     rst;
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*CNT_W-1:0] dur;
  logic [NUM_REQ-1:0]       grant;
  logic [NUM_REQ-1:0]       done;
  logic                     busy;
  logic                     tick;

  int checks   = 0;
  int failures = 0;

  timer_arbiter #(
    .NUM_REQ (NUM_REQ),
    .DIV     (DIV),
    .CNT_W   (CNT_W)
  ) u_dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .dur   (dur),
    .grant (grant),
    .done  (done),
    .busy  (busy),
    .tick  (tick)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_grant"}, {28'd0, grant}, 32'd0);
    chk({tag, "_done"},  {28'd0, done},  32'd0);
    chk({tag, "_busy"},  {31'd0, busy},  32'd0);
    chk({tag, "_tick"},  {31'd0, tick},  32'd0);
  endtask

  // Called in the cycle the arbiter sees the request (cycle C). Checks every
  // cycle up to C+n*DIV+1. drop_at>0 lowers req[who] after checking cycle
  // C+drop_at; with the abort build the interval then ends silently.
  task automatic run_one(input string tag, input int who, input int n, input int drop_at);
    logic [3:0] oh;
    bit         aborted;
    bit         live;
    oh = 4'b0001 << who;
    for (int cyc = 1; cyc <= n*DIV + 1; cyc++) begin
      step();
      aborted = 1'b0;
`ifdef TIMER_ARBITER_ABORT_EN
      aborted = (drop_at != 0) && (cyc > drop_at);
`endif
      live = !aborted && (cyc <= n*DIV);
      chk({tag, "_grant"}, {28'd0, grant}, live ? {28'd0, oh} : 32'd0);
      chk({tag, "_tick"},  {31'd0, tick},  (live && (cyc % DIV == 0)) ? 32'd1 : 32'd0);
      chk({tag, "_done"},  {28'd0, done},
          (!aborted && (cyc == n*DIV + 1)) ? {28'd0, oh} : 32'd0);
      chk({tag, "_busy"},  {31'd0, busy},  aborted ? 32'd0 : 32'd1);
      if (cyc == drop_at) req[who] = 1'b0;
    end
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    req = 4'b1111;
    dur = 32'h01010101;

    // Reset held with all requests active: everything quiet.
    repeat (3) begin
      step();
      chk_idle("reset");
    end

    // Round-robin among 0,1,3 with unit durations, starting at requester 0.
    rst = 1'b0;
    req = 4'b1011;
    run_one("rr0a", 0, 1, 0);
    step(); chk_idle("rr_gap1");
    run_one("rr1a", 1, 1, 0);
    step(); chk_idle("rr_gap2");
    run_one("rr3a", 3, 1, 0);
    step(); chk_idle("rr_gap3");
    run_one("rr0b", 0, 1, 0);
    step(); chk_idle("rr_gap4");
    run_one("rr1b", 1, 1, 0);
    step(); chk_idle("rr_gap5");
    run_one("rr3b", 3, 1, 0);
    req = 4'b0000;
    step(); chk_idle("rr_end");

    // Single request, three ticks.
    req = 4'b0100;
    dur = 32'h01030101;
    run_one("single", 2, 3, 0);
    req = 4'b0000;
    step(); chk_idle("single_end");

    // Zero duration: immediate done, no grant, no tick.
    req = 4'b0010;
    dur = 32'h01030001;
    step();
    chk("zero_done",  {28'd0, done},  32'h2);
    chk("zero_grant", {28'd0, grant}, 32'h0);
    chk("zero_busy",  {31'd0, busy},  32'h1);
    chk("zero_tick",  {31'd0, tick},  32'h0);
    req = 4'b0000;
    step(); chk_idle("zero_end");

    // Owner drops its request six cycles into a five-tick interval.
    req = 4'b0001;
    dur = 32'h01030005;
    run_one("abort", 0, 5, 6);
    step(); chk_idle("abort_end");

    // Reset in the middle of requester 3's interval; afterwards requester 0
    // wins because reset restores the start pointer.
    req = 4'b1001;
    dur = 32'h03030001;
    step();
    chk("midrst_grant3", {28'd0, grant}, 32'h8);
    repeat (4) step();
    rst = 1'b1;
    step();
    chk_idle("midrst");
    rst = 1'b0;
    run_one("midrst_r0", 0, 1, 0);
    req = 4'b0000;
    step(); chk_idle("midrst_end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
